// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a word count followed by a little-endian program
// image and writes it into instruction memory while holding the core in reset.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      CAPACITY = 17'd1 << ADDR_W;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_CNT_LO, L_CNT_HI, L_DATA, L_DONE, L_ERROR} ld_state_t;

    // ---------------- rx synchronizer ----------------
    logic r_rx_meta, r_rx_sync, r_rx_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ---------------- receiver FSM ----------------
    rx_state_t        r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid, r_frame_err;
    logic             w_half, w_full, w_byte_valid_next, w_frame_err_next;

    assign w_half = (r_clk_cnt == HALF_M1);
    assign w_full = (r_clk_cnt == FULL_M1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_rx_state <= R_IDLE;
        else         r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_next = R_START;
            R_START: if (w_half) w_rx_state_next = r_rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (w_full && r_bit_idx == 3'd7) w_rx_state_next = R_STOP;
            R_STOP:  if (w_full) w_rx_state_next = R_IDLE;
            default: w_rx_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_byte_valid_next = 1'b0;
        w_frame_err_next  = 1'b0;
        if (r_rx_state == R_STOP && w_full) begin
            w_byte_valid_next = r_rx_sync;
            w_frame_err_next  = !r_rx_sync;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_valid_next;
            r_frame_err  <= w_frame_err_next;
            case (r_rx_state)
                R_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                end
                R_START: r_clk_cnt <= w_half ? '0 : r_clk_cnt + CNT_W'(1);
                R_DATA: begin
                    if (w_full) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                R_STOP: r_clk_cnt <= w_full ? '0 : r_clk_cnt + CNT_W'(1);
                default: r_clk_cnt <= '0;
            endcase
        end
    end

    // ---------------- loader FSM ----------------
    ld_state_t         r_ld_state, w_ld_state_next;
    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word, w_word_next;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic [15:0]       w_n;
    logic              w_last_word;

    assign w_n         = {r_shift, r_count[7:0]};
    assign w_last_word = (17'(r_word_idx) == (17'(r_count) - 17'd1));

    // The incoming byte replaces only the lane selected by the byte counter.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_word_next[8*gi +: 8] = (r_byte_idx == 2'(gi)) ? r_shift : r_word[8*gi +: 8];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_ld_state <= L_CNT_LO;
        else         r_ld_state <= w_ld_state_next;
    end

    always_comb begin
        w_ld_state_next = r_ld_state;
        case (r_ld_state)
            L_CNT_LO: begin
                if (r_frame_err)       w_ld_state_next = L_ERROR;
                else if (r_byte_valid) w_ld_state_next = L_CNT_HI;
            end
            L_CNT_HI: begin
                if (r_frame_err) begin
                    w_ld_state_next = L_ERROR;
                end else if (r_byte_valid) begin
                    if (w_n == 16'd0)              w_ld_state_next = L_DONE;
                    else if (17'(w_n) > CAPACITY)  w_ld_state_next = L_ERROR;
                    else                           w_ld_state_next = L_DATA;
                end
            end
            L_DATA: begin
                if (r_frame_err)                   w_ld_state_next = L_ERROR;
                else if (r_imem_we && w_last_word) w_ld_state_next = L_DONE;
            end
            L_DONE:  w_ld_state_next = L_DONE;
            default: w_ld_state_next = L_ERROR;
        endcase
    end

    always_comb begin
        o_done     = 1'b0;
        o_err      = 1'b0;
        o_cpu_hold = 1'b1;
        case (r_ld_state)
            L_DONE: begin
                o_done     = 1'b1;
                o_cpu_hold = 1'b0;
            end
            L_ERROR: o_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (r_imem_we) r_word_idx <= r_word_idx + ADDR_W'(1);
            if (r_byte_valid) begin
                case (r_ld_state)
                    L_CNT_LO: r_count[7:0]  <= r_shift;
                    L_CNT_HI: r_count[15:8] <= r_shift;
                    L_DATA: begin
                        r_word     <= w_word_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_wdata <= w_word_next;
                            r_imem_addr  <= r_word_idx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with CLKS_PER_BIT=4, ADDR_W=4.
module tb_imem_uart_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, done, err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_cpu_hold  (cpu_hold),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobe, longest strobe run and event cycles.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          we_run = 0;
    int          we_run_max = 0;
    int          last_we_cyc = -1;
    int          done_cyc = -1;
    logic [AW-1:0] wr_addr [32];
    logic [31:0]   wr_data [32];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            wr_cnt      <= 0;
            we_run      <= 0;
            we_run_max  <= 0;
            last_we_cyc <= -1;
            done_cyc    <= -1;
        end else begin
            if (imem_we) begin
                if (wr_cnt < 32) begin
                    wr_addr[wr_cnt] <= imem_addr;
                    wr_data[wr_cnt] <= imem_wdata;
                end
                $display("write  addr=%0d data=%08h", imem_addr, imem_wdata);
                wr_cnt      <= wr_cnt + 1;
                we_run      <= we_run + 1;
                we_run_max  <= (we_run + 1 > we_run_max) ? we_run + 1 : we_run_max;
                last_we_cyc <= cyc;
            end else begin
                we_run <= 0;
            end
            if (done && done_cyc < 0) done_cyc <= cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        $display("rx byte %02h stop=%0b", b, stop_bit);
    endtask

    task automatic send4(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++;
        if ({imem_we, imem_addr, imem_wdata} !== '0) $display("FAIL reset_write_port: got we=%b addr=%h data=%h required all 0", imem_we, imem_addr, imem_wdata);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b100) $display("FAIL reset_status: got hold/done/err=%b required 100", {cpu_hold, done, err});
        else pass_cnt++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_two_words();
        apply_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send4(8'h13, 8'h00, 8'h50, 8'h00);
        send4(8'h6F, 8'h00, 8'h00, 8'h00);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 2) $display("FAIL two_words_count: got %0d required 2", wr_cnt);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h00500013) $display("FAIL two_words_w0: got %0d:%08h required 0:00500013", wr_addr[0], wr_data[0]);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[1] !== 4'd1 || wr_data[1] !== 32'h0000006F) $display("FAIL two_words_w1: got %0d:%08h required 1:0000006f", wr_addr[1], wr_data[1]);
        else pass_cnt++;
        check_cnt++;
        if (we_run_max !== 1) $display("FAIL two_words_we_width: got %0d required 1", we_run_max);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b010) $display("FAIL two_words_status: got hold/done/err=%b required 010", {cpu_hold, done, err});
        else pass_cnt++;
        check_cnt++;
        if (done_cyc - last_we_cyc !== 1) $display("FAIL two_words_done_latency: got %0d required 1", done_cyc - last_we_cyc);
        else pass_cnt++;
        check_cnt++;
        if (imem_addr !== 4'd1 || imem_wdata !== 32'h0000006F) $display("FAIL two_words_hold_last: got %0d:%08h required 1:0000006f", imem_addr, imem_wdata);
        else pass_cnt++;
        // bytes after completion are ignored
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 2 || done !== 1'b1) $display("FAIL done_ignores_rx: got writes=%0d done=%b required 2 1", wr_cnt, done);
        else pass_cnt++;
    endtask

    task automatic test_zero_count();
        apply_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 0) $display("FAIL zero_count_writes: got %0d required 0", wr_cnt);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b010) $display("FAIL zero_count_status: got hold/done/err=%b required 010", {cpu_hold, done, err});
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        apply_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        send4(8'h01, 8'h02, 8'h03, 8'h04);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 0) $display("FAIL overflow_writes: got %0d required 0", wr_cnt);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b101) $display("FAIL overflow_status: got hold/done/err=%b required 101", {cpu_hold, done, err});
        else pass_cnt++;
    endtask

    task automatic test_framing();
        apply_reset();
        send4(8'h01, 8'h00, 8'hAA, 8'hBB);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 0) $display("FAIL framing_writes: got %0d required 0", wr_cnt);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b101) $display("FAIL framing_status: got hold/done/err=%b required 101", {cpu_hold, done, err});
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        apply_reset();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send4(8'h01, 8'h00, 8'hEF, 8'hBE);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 1) $display("FAIL glitch_count: got %0d required 1", wr_cnt);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'hDEADBEEF) $display("FAIL glitch_word: got %0d:%08h required 0:deadbeef", wr_addr[0], wr_data[0]);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b010) $display("FAIL glitch_status: got hold/done/err=%b required 010", {cpu_hold, done, err});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send4(8'h02, 8'h00, 8'h11, 8'h22);
        // abort part-way through the next frame
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_cnt++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, err} !== {1'b0, 4'd0, 32'd0, 3'b100}) $display("FAIL midreset_outputs: got we=%b addr=%h data=%h hold/done/err=%b required 0 0 0 100", imem_we, imem_addr, imem_wdata, {cpu_hold, done, err});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (6) @(negedge clk);
        send4(8'h01, 8'h00, 8'h78, 8'h56);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 1) $display("FAIL midreset_count: got %0d required 1", wr_cnt);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h12345678) $display("FAIL midreset_word: got %0d:%08h required 0:12345678", wr_addr[0], wr_data[0]);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, done, err} !== 3'b010) $display("FAIL midreset_status: got hold/done/err=%b required 010", {cpu_hold, done, err});
        else pass_cnt++;
    endtask

    task automatic test_full_capacity();
        int bad;
        apply_reset();
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int w = 0; w < 16; w++) begin
            send4(8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3));
            check_cnt++;
            if (done !== (w == 15)) $display("FAIL full_done_word%0d: got done=%b required %b", w, done, (w == 15));
            else pass_cnt++;
        end
        repeat (10) @(negedge clk);
        check_cnt++;
        if (wr_cnt !== 16) $display("FAIL full_count: got %0d required 16", wr_cnt);
        else pass_cnt++;
        bad = -1;
        for (int w = 15; w >= 0; w--) begin
            if (wr_addr[w] !== 4'(w) || wr_data[w] !== {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}) bad = w;
        end
        check_cnt++;
        if (bad >= 0) $display("FAIL full_words: word %0d got %0d:%08h", bad, wr_addr[bad], wr_data[bad]);
        else pass_cnt++;
        check_cnt++;
        if (done_cyc - last_we_cyc !== 1 || err !== 1'b0) $display("FAIL full_done: got latency=%0d err=%b required 1 0", done_cyc - last_we_cyc, err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_overflow();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_full_capacity();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Boot-time writer for the instruction memory, the producer side of the read-only instruction-fetch path the core uses.
- Receives a program image over a UART serial line.
- Assembles little-endian 32-bit words and issues single-cycle word writes into the instruction memory's write port.
- Holds the core in reset until the image is complete. One-shot: a new load requires reset.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Must be >= 4.
- ADDR_W, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  UART serial in; idles high; 8N1, LSB first
- imem_we  output  1  one-cycle word write strobe
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  write data
- cpu_hold  output  1  high keeps the core in reset
- done  output  1  image fully written (sticky)
- err  output  1  protocol/framing error (sticky)

Behaviour:
- Reset (async, active-high) values:
  - imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, done=0, err=0
  - FSM=CNT_LO, byte counter=0, word counter=0
  - rx synchronizer flops=1
- rx path: two-flop synchronizer before any use.
- Receiver FSM: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a synchronized 1->0 transition moves to R_START with the bit counter cleared.
  - R_START: sample at CLKS_PER_BIT/2 cycles. Low moves to R_DATA; high is a false start and returns to R_IDLE with no error.
  - R_DATA: sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - Stop=1: emit an internal byte_valid pulse for 1 cycle, then R_IDLE.
    - Stop=0: framing error, then R_IDLE.
- Loader FSM: CNT_LO, CNT_HI, DATA, DONE, ERROR.
  - CNT_LO: first byte = word count N[7:0].
  - CNT_HI: second byte = N[15:8].
    - N=0: go to DONE.
    - N>2^ADDR_W: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: bytes shift into the word little-endian; byte k of a word lands in bits [8k+7:8k].
    - On the 4th byte_valid, the next cycle drives imem_we=1 with imem_wdata=the word and imem_addr=the current word index.
    - The word index increments on the cycle after the strobe.
    - After word N-1 is written, go to DONE.
  - DONE: done=1 and cpu_hold=0 starting the cycle after the final imem_we. Further rx bytes are ignored. No writes.
  - ERROR: err=1 and cpu_hold stays 1 until reset. No further writes.
- A framing error in any loader state except DONE goes to ERROR. A partial word is discarded.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- No write ever occurs with imem_addr >= N.
- Word index wrap: impossible, because N is bounded by capacity. N = 2^ADDR_W writes addresses 0 .. 2^ADDR_W-1, then DONE.
- Latency, from the stop-bit sample of the 4th byte:
  - byte_valid: +1 cycle
  - imem_we: +2 cycles
  - done (last word): +3 cycles
- Reset asserted mid-frame or mid-word aborts immediately: outputs return to reset values, the partial word is lost, and the image restarts from the count bytes.
- A glitch shorter than CLKS_PER_BIT/2 on idle rx does not produce a byte.

Test Plan:
- CLKS_PER_BIT=4, ADDR_W=4. Send 02 00, then 13 00 50 00, then 6F 00 00 00.
  - Writes: addr0 = 0x00500013, then addr1 = 0x0000006F, each a single-cycle imem_we.
  - Then done=1, cpu_hold=0, err=0.
- Send 00 00.
  - No imem_we. done=1 and cpu_hold=0 one cycle after the second byte_valid.
- ADDR_W=4, send 11 00 (N=17 > 16).
  - err=1, cpu_hold=1, no writes. Subsequent bytes are ignored.
- Send 01 00 AA BB, then a byte with stop bit=0.
  - err=1, no write occurs, cpu_hold stays 1.
- Pulse rx low for 1 cycle while idle, then send a valid 01 00 EF BE AD DE.
  - The glitch is ignored. A single write of 0xDEADBEEF goes to addr0, then done=1.
- Send 02 00 plus 2 bytes, assert reset for 1 cycle, then send a full 01 00 78 56 34 12.
  - All outputs return to reset values during reset.
  - A single write of 0x12345678 goes to addr0, then done=1.
